// File: rtl/adpcm_pkg.sv
// Shared constants and types for the multi-channel IMA-ADPCM decoder.
// Holds the 89-entry IMA step-size table, the index adaptation table,
// the step-index type and its upper limit. No ports.
package adpcm_pkg;

  localparam int unsigned IDX_MAX = 88;
  localparam int unsigned STEP_W  = 16;
  localparam int unsigned ADJ_W   = 5;

  typedef logic [6:0] step_idx_t;

  // IMA step sizes indexed by step index 0..88
  localparam logic [STEP_W-1:0] STEP_TABLE [0:88] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  // Step-index adjustment by code magnitude; +8 needs five signed bits
  localparam logic signed [ADJ_W-1:0] INDEX_ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

endpackage

// File: rtl/adpcm_decoder_mc_if.sv
// Stream bundle for adpcm_decoder_mc.
// Code input:   in_valid/in_ready, in_code (4b), in_chan.
// State init:   init_valid/init_ready, init_chan, init_predictor, init_index.
// Sample output: out_valid/out_ready, out_sample, out_chan, out_clip.
// master = upstream/downstream environment, slave = decoder.
interface adpcm_decoder_mc_if
  import adpcm_pkg::*;
#(
  parameter int unsigned CH_W     = 1,
  parameter int unsigned SAMPLE_W = 16
);

  logic                       in_valid;
  logic                       in_ready;
  logic [3:0]                 in_code;
  logic [CH_W-1:0]            in_chan;

  logic                       init_valid;
  logic                       init_ready;
  logic [CH_W-1:0]            init_chan;
  logic signed [SAMPLE_W-1:0] init_predictor;
  step_idx_t                  init_index;

  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic [CH_W-1:0]            out_chan;
  logic                       out_clip;

  modport master (
    output in_valid, in_code, in_chan,
    output init_valid, init_chan, init_predictor, init_index,
    output out_ready,
    input  in_ready, init_ready, out_valid, out_sample, out_chan, out_clip
  );

  modport slave (
    input  in_valid, in_code, in_chan,
    input  init_valid, init_chan, init_predictor, init_index,
    input  out_ready,
    output in_ready, init_ready, out_valid, out_sample, out_chan, out_clip
  );

endinterface

// File: rtl/adpcm_step_core.sv
// Combinational IMA-ADPCM inverse quantiser: one decode step.
// Inputs:  pred (signed predictor), idx (step index 0..88), code (nibble).
// Outputs: new_pred (saturated), new_idx (adapted, clamped), clip.
module adpcm_step_core
  import adpcm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic signed [SAMPLE_W-1:0] pred,
  input  step_idx_t                  idx,
  input  logic [3:0]                 code,
  output logic signed [SAMPLE_W-1:0] new_pred,
  output step_idx_t                  new_idx,
  output logic                       clip
);

  localparam int unsigned SUM_W = SAMPLE_W + 2;

  logic [STEP_W-1:0]       step;
  logic [STEP_W:0]         diff;
  logic signed [SUM_W-1:0] pred_x;
  logic signed [SUM_W-1:0] diff_x;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sat_max;
  logic signed [SUM_W-1:0] sat_min;
  logic signed [7:0]       idx_sum;

  // Predictor update with saturation
  always_comb begin
    step    = STEP_TABLE[idx];
    diff    = 17'(step >> 3);
    if (code[2]) diff = diff + 17'(step);
    if (code[1]) diff = diff + 17'(step >> 1);
    if (code[0]) diff = diff + 17'(step >> 2);
    pred_x  = SUM_W'(pred);
    diff_x  = SUM_W'($signed({1'b0, diff}));
    sum     = code[3] ? (pred_x - diff_x) : (pred_x + diff_x);
    sat_max = {3'b000, {(SAMPLE_W-1){1'b1}}};
    sat_min = {3'b111, {(SAMPLE_W-1){1'b0}}};
    clip     = 1'b0;
    new_pred = sum[SAMPLE_W-1:0];
    if (sum > sat_max) begin
      new_pred = {1'b0, {(SAMPLE_W-1){1'b1}}};
      clip     = 1'b1;
    end else if (sum < sat_min) begin
      new_pred = {1'b1, {(SAMPLE_W-1){1'b0}}};
      clip     = 1'b1;
    end
  end

  // Step-index adaptation clamped to the table range
  always_comb begin
    idx_sum = $signed({1'b0, idx}) + 8'(INDEX_ADJ[code[2:0]]);
    new_idx = idx_sum[6:0];
    if (idx_sum < 8'sd0)                       new_idx = '0;
    else if (idx_sum > $signed(8'(IDX_MAX)))   new_idx = step_idx_t'(IDX_MAX);
  end

endmodule

// File: rtl/adpcm_decoder_mc.sv
// Multi-channel pipelined IMA-ADPCM decoder.
// Ports: clk, rst (sync, active-high), bus (adpcm_decoder_mc_if.slave):
//   codes in via in_*, per-channel state loads via init_*, samples out via out_*.
// S1 registers code/channel; S2 decodes against per-channel state and
// registers the sample while writing the state back at the same edge.
module adpcm_decoder_mc
  import adpcm_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SAMPLE_W = 16,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  adpcm_decoder_mc_if.slave   bus
);

  logic                       advance;
  logic                       in_fire;
  logic                       init_fire;
  logic                       in_chan_ok;
  logic                       init_chan_ok;

  logic                       s1_valid;
  logic [3:0]                 s1_code;
  logic [CH_W-1:0]            s1_chan;

  logic signed [SAMPLE_W-1:0] pred_q [CHANNELS];
  step_idx_t                  idx_q  [CHANNELS];

  logic signed [SAMPLE_W-1:0] new_pred;
  step_idx_t                  new_idx;
  logic                       clip;

  // Handshake decode; init wins over codes and waits for S1 to drain
  always_comb begin
    advance        = !bus.out_valid || bus.out_ready;
    bus.in_ready   = advance && !bus.init_valid && !rst;
    bus.init_ready = !s1_valid && !rst;
    in_fire        = bus.in_valid && bus.in_ready;
    init_fire      = bus.init_valid && bus.init_ready;
    in_chan_ok     = 32'(bus.in_chan) < CHANNELS;
    init_chan_ok   = 32'(bus.init_chan) < CHANNELS;
  end

  adpcm_step_core #(.SAMPLE_W(SAMPLE_W)) u_step (
    .pred     (pred_q[s1_chan]),
    .idx      (idx_q[s1_chan]),
    .code     (s1_code),
    .new_pred (new_pred),
    .new_idx  (new_idx),
    .clip     (clip)
  );

  // Pipeline stages and per-channel state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        pred_q[c] <= '0;
        idx_q[c]  <= '0;
      end
      s1_valid       <= 1'b0;
      s1_code        <= '0;
      s1_chan        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sample <= '0;
      bus.out_chan   <= '0;
      bus.out_clip   <= 1'b0;
    end else begin
      if (advance) begin
        // out-of-range channels are accepted but never enter S1
        s1_valid      <= in_fire && in_chan_ok;
        s1_code       <= bus.in_code;
        s1_chan       <= bus.in_chan;
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_sample   <= new_pred;
          bus.out_chan     <= s1_chan;
          bus.out_clip     <= clip;
          pred_q[s1_chan]  <= new_pred;
          idx_q[s1_chan]   <= new_idx;
        end
      end
      // only possible with S1 empty, so never collides with the S2 write
      if (init_fire && init_chan_ok) begin
        pred_q[bus.init_chan] <= bus.init_predictor;
        idx_q[bus.init_chan]  <= (bus.init_index > step_idx_t'(IDX_MAX)) ?
                                 step_idx_t'(IDX_MAX) : bus.init_index;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_decoder_mc.sv
// Directed self-checking bench for adpcm_decoder_mc (2 channels, 16-bit).
module tb_adpcm_decoder_mc;
  import adpcm_pkg::*;

  localparam int unsigned CHANNELS = 2;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CH_W     = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  adpcm_decoder_mc_if #(.CH_W(CH_W), .SAMPLE_W(SAMPLE_W)) bus ();

  adpcm_decoder_mc #(.CHANNELS(CHANNELS), .SAMPLE_W(SAMPLE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid       = 1'b0;
    bus.in_code        = 4'd0;
    bus.in_chan        = '0;
    bus.init_valid     = 1'b0;
    bus.init_chan      = '0;
    bus.init_predictor = '0;
    bus.init_index     = '0;
    bus.out_ready      = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_code(input logic [CH_W-1:0] ch, input logic [3:0] code);
    bus.in_valid = 1'b1;
    bus.in_chan  = ch;
    bus.in_code  = code;
  endtask

  // One isolated code through the pipe; returns what appears at the output
  task automatic decode_one(input logic [CH_W-1:0] ch, input logic [3:0] code,
                            output logic vld, output logic signed [15:0] smp,
                            output logic clp, output logic [CH_W-1:0] chn);
    drive_code(ch, code);
    tick();
    bus.in_valid = 1'b0;
    tick();
    vld = bus.out_valid;
    smp = bus.out_sample;
    clp = bus.out_clip;
    chn = bus.out_chan;
  endtask

  // Load channel state; ok = 0 if init_ready never rose
  task automatic init_load(input logic [CH_W-1:0] ch, input logic signed [15:0] p,
                           input step_idx_t ix, output logic ok);
    ok = 1'b0;
    bus.init_valid     = 1'b1;
    bus.init_chan      = ch;
    bus.init_predictor = p;
    bus.init_index     = ix;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (bus.init_ready) ok = 1'b1;
      tick();
    end
    bus.init_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.init_ready !== 1'b0) begin errors++; $display("FAIL reset_init_ready: got %b want 0", bus.init_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sample !== 16'sd0 || bus.out_clip !== 1'b0 || bus.out_chan !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: valid=%b sample=%0d clip=%b chan=%0d want all 0", bus.out_valid, bus.out_sample, bus.out_clip, bus.out_chan); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.init_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset_ready: in_ready=%b init_ready=%b want 1 1", bus.in_ready, bus.init_ready); end
    tick();
  endtask

  task automatic test_decode();
    logic vld; logic signed [15:0] smp; logic clp; logic [CH_W-1:0] chn;
    do_reset();
    decode_one(1'b0, 4'b0111, vld, smp, clp, chn);
    checks++; if (vld !== 1'b1 || smp !== 16'sd11 || clp !== 1'b0 || chn !== 1'b0)
      begin errors++; $display("FAIL decode_first: valid=%b sample=%0d clip=%b chan=%0d want 1 11 0 0", vld, smp, clp, chn); end
    decode_one(1'b0, 4'b0111, vld, smp, clp, chn);
    checks++; if (vld !== 1'b1 || smp !== 16'sd41 || clp !== 1'b0)
      begin errors++; $display("FAIL decode_second: valid=%b sample=%0d clip=%b want 1 41 0", vld, smp, clp); end
  endtask

  task automatic test_clamp_low();
    logic vld; logic signed [15:0] smp; logic clp; logic [CH_W-1:0] chn;
    do_reset();
    decode_one(1'b0, 4'b1000, vld, smp, clp, chn);
    checks++; if (vld !== 1'b1 || smp !== 16'sd0 || clp !== 1'b0)
      begin errors++; $display("FAIL clamp_low_zero: valid=%b sample=%0d clip=%b want 1 0 0", vld, smp, clp); end
    decode_one(1'b0, 4'b1111, vld, smp, clp, chn);
    checks++; if (smp !== -16'sd11 || clp !== 1'b0)
      begin errors++; $display("FAIL clamp_low_neg: sample=%0d clip=%b want -11 0", smp, clp); end
  endtask

  task automatic test_saturate();
    logic vld; logic signed [15:0] smp; logic clp; logic [CH_W-1:0] chn; logic ok;
    do_reset();
    init_load(1'b1, 16'sd32700, 7'd88, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout_a: init_ready got 0 want 1"); end
    decode_one(1'b1, 4'b0111, vld, smp, clp, chn);
    checks++; if (vld !== 1'b1 || smp !== 16'sd32767 || clp !== 1'b1 || chn !== 1'b1)
      begin errors++; $display("FAIL sat_high: valid=%b sample=%0d clip=%b chan=%0d want 1 32767 1 1", vld, smp, clp, chn); end
    // step at idx 88 is 32767 -> diff 4095; proves idx stayed at 88
    decode_one(1'b1, 4'b1000, vld, smp, clp, chn);
    checks++; if (smp !== 16'sd28672 || clp !== 1'b0)
      begin errors++; $display("FAIL sat_idx_hold: sample=%0d clip=%b want 28672 0", smp, clp); end
    init_load(1'b0, 16'sd0, 7'd127, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout_b: init_ready got 0 want 1"); end
    decode_one(1'b0, 4'b0000, vld, smp, clp, chn);
    checks++; if (smp !== 16'sd4095 || clp !== 1'b0 || chn !== 1'b0)
      begin errors++; $display("FAIL init_idx_clamp: sample=%0d clip=%b chan=%0d want 4095 0 0", smp, clp, chn); end
    init_load(1'b1, -16'sd32700, 7'd88, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout_c: init_ready got 0 want 1"); end
    decode_one(1'b1, 4'b1111, vld, smp, clp, chn);
    checks++; if (smp !== -16'sd32768 || clp !== 1'b1)
      begin errors++; $display("FAIL sat_low: sample=%0d clip=%b want -32768 1", smp, clp); end
  endtask

  task automatic test_back_to_back();
    int exp_s [8] = '{11, 11, 41, 41, 104, 104, 240, 240};
    logic signed [15:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive_code(1'(i % 2), 4'b0111);
      else       bus.in_valid = 1'b0;
      if (i == 1) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_latency: out_valid got %b want 0", bus.out_valid); end
      end
      if (i >= 2) begin
        e = 16'(exp_s[i-2]);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sample !== e || bus.out_chan !== 1'((i - 2) % 2))
          begin errors++; $display("FAIL b2b_%0d: valid=%b sample=%0d chan=%0d want 1 %0d %0d", i - 2, bus.out_valid, bus.out_sample, bus.out_chan, e, (i - 2) % 2); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int exp_s [5] = '{11, 41, 104, 240, 533};
    logic signed [15:0] e;
    int sent = 0;
    int got  = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc <= 6);
      bus.in_valid  = (sent < 5);
      bus.in_chan   = 1'b0;
      bus.in_code   = 4'b0111;
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d: got %b want 0", cyc, bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd11)
          begin errors++; $display("FAIL stall_hold_c%0d: valid=%b sample=%0d want 1 11", cyc, bus.out_valid, bus.out_sample); end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        e = (got < 5) ? 16'(exp_s[got]) : 16'sd0;
        checks++; if (bus.out_sample !== e) begin errors++; $display("FAIL bp_order_%0d: got %0d want %0d", got, bus.out_sample, e); end
        got++;
      end
      @(posedge clk);
      #1;
    end
    idle();
    checks++; if (got != 5 || sent != 5) begin errors++; $display("FAIL bp_count: got %0d/%0d samples/codes want 5/5", got, sent); end
  endtask

  task automatic test_init_priority();
    do_reset();
    drive_code(1'b0, 4'b0111);
    tick();
    bus.init_valid     = 1'b1;
    bus.init_chan      = 1'b0;
    bus.init_predictor = 16'sd1000;
    bus.init_index     = 7'd0;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.init_ready !== 1'b0)
      begin errors++; $display("FAIL prio_blocked: in_ready=%b init_ready=%b want 0 0", bus.in_ready, bus.init_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd11)
      begin errors++; $display("FAIL prio_drain: valid=%b sample=%0d want 1 11", bus.out_valid, bus.out_sample); end
    checks++; if (bus.init_ready !== 1'b1 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL prio_init_ready: init_ready=%b in_ready=%b want 1 0", bus.init_ready, bus.in_ready); end
    tick();
    bus.init_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL prio_resume: in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sample !== 16'sd1011 || bus.out_chan !== 1'b0)
      begin errors++; $display("FAIL prio_uses_init: valid=%b sample=%0d chan=%0d want 1 1011 0", bus.out_valid, bus.out_sample, bus.out_chan); end
  endtask

  task automatic test_reset_mid();
    logic vld; logic signed [15:0] smp; logic clp; logic [CH_W-1:0] chn;
    do_reset();
    drive_code(1'b0, 4'b0111);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_reset: out_valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready); end
    idle();
    rst = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_flush: out_valid got %b want 0", bus.out_valid); end
    decode_one(1'b0, 4'b0111, vld, smp, clp, chn);
    checks++; if (vld !== 1'b1 || smp !== 16'sd11)
      begin errors++; $display("FAIL mid_reset_state: valid=%b sample=%0d want 1 11", vld, smp); end
  endtask

  initial begin
    idle();
    test_reset();
    test_decode();
    test_clamp_low();
    test_saturate();
    test_back_to_back();
    test_backpressure();
    test_init_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
